// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq -- load/store sequencer in front of a byte-wide data memory.
//
// Accepts one byte/halfword/word request at a time, walks it through the
// memory one byte per cycle (little-endian, address wraps modulo 2^AW) and
// returns either the sign/zero-extended load value or a store completion.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : misaligned half (addr[0]=1) or word (addr[1:0]!=0) requests
//               complete immediately with rsp_err_o = 1 and no memory access.
//   undefined : misaligned requests execute byte by byte with address wrap;
//               only size 2'b11 is reported as an error.
//
// Handshake: a request is taken at the rising edge where
// req_valid_i & req_ready_o are both high; req_ready_o is high only in IDLE,
// so request inputs matter only in that cycle. rsp_valid_o is a single-cycle
// pulse with no backpressure; rsp_rdata_o/rsp_err_o hold until the next one.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_we_i                 1 = store, 0 = load
//   req_size_i               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i           load zero-extend (1) / sign-extend (0)
//   req_addr_i, req_wdata_i  base byte address, store data (byte 0 = [7:0])
//   rsp_valid_o              one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o   load result and error flag
//   mem_addr_o, mem_wdata_o, mem_we_o, mem_rdata_i   byte memory port
//   dbg_state_o              current FSM state (IDLE=0, ACCESS=1, RESP=2)

module lsu_byte_seq #(
    parameter int AW = 11,
    parameter int DW = 32  // fixed at 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    output logic          mem_we_o,
    input  logic [7:0]    mem_rdata_i,
    output logic [1:0]    dbg_state_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [1:0]    cnt;
    logic [DW-1:0] asm_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;

    logic          req_err;
    logic [1:0]    last_cnt;
    logic [DW-1:0] asm_next;
    logic [DW-1:0] load_ext;
    logic          ext_bit;
    logic [4:0]    bit_ofs;

    assign bit_ofs = {cnt, 3'b000};

    // Request legality, evaluated on the live request inputs in IDLE.
    always_comb begin
        req_err = (req_size_i == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
        if ((req_size_i == 2'b01) && req_addr_i[0])
            req_err = 1'b1;
        if ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    // Index of the final byte of the latched request (1/2/4 bytes).
    always_comb begin
        case (size_q)
            2'b00:   last_cnt = 2'd0;
            2'b01:   last_cnt = 2'd1;
            default: last_cnt = 2'd3;
        endcase
    end

    // Assembly register with the byte being read this cycle merged in, so
    // the final load value is ready at the edge that ends the last access.
    always_comb begin
        asm_next = asm_q;
        asm_next[bit_ofs +: 8] = mem_rdata_i;
    end

    always_comb begin
        ext_bit  = 1'b0;
        load_ext = asm_next;
        case (size_q)
            2'b00: begin
                ext_bit  = ~uns_q & asm_next[7];
                load_ext = {{24{ext_bit}}, asm_next[7:0]};
            end
            2'b01: begin
                ext_bit  = ~uns_q & asm_next[15];
                load_ext = {{16{ext_bit}}, asm_next[15:0]};
            end
            default: load_ext = asm_next;
        endcase
    end

    // Outputs are decoded from the registered state, so reset forces them
    // to their idle values asynchronously.
    always_comb begin
        req_ready_o = (state == IDLE);
        rsp_valid_o = (state == RESP);
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 8'h00;
        if (state == ACCESS) begin
            mem_addr_o = addr_q + {{(AW-2){1'b0}}, cnt};
            mem_we_o   = we_q;
            if (we_q)
                mem_wdata_o = wdata_q[bit_ofs +: 8];
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign dbg_state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= 2'd0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        size_q  <= req_size_i;
                        uns_q   <= req_unsigned_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        cnt     <= 2'd0;
                        asm_q   <= '0;
                        if (req_err) begin
                            // Error skips the memory entirely.
                            state   <= RESP;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q)
                        asm_q <= asm_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == last_cnt) begin
                        state   <= RESP;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : load_ext;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Testbench for lsu_byte_seq: byte memory model, directed scenarios followed
// by randomized requests, checked against a byte-level reference model.

module tb_lsu_byte_seq;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [10:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [10:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_we_o;
    logic [7:0]  mem_rdata_i;
    logic [1:0]  dbg_state_o;

    lsu_byte_seq #(.AW(11), .DW(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_we_o       (mem_we_o),
        .mem_rdata_i    (mem_rdata_i),
        .dbg_state_o    (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- memory (environment) ----------------
    logic [7:0]  mem [2048];
    logic        fill_en;
    logic [7:0]  fill_seed;
    logic        bd_we;
    logic [10:0] bd_addr;
    logic [7:0]  bd_data;

    always @(posedge clk_i) begin
        if (fill_en) begin
            for (int i = 0; i < 2048; i++)
                mem[i] <= 8'(i * 37 + 11) ^ fill_seed;
        end else if (mem_we_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end
    end

    assign mem_rdata_i = mem[mem_addr_o];

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]  ref_mem [2048];
    logic [19:0] exp_q [$];   // {we, addr, data} per expected memory access
    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [1:0] size, input logic [10:0] addr);
        bit e;
        e = (size == 2'b11);
`ifdef LSU_ALIGN_CHECK_EN
        if (size == 2'b01 && (addr % 2) != 0) e = 1;
        if (size == 2'b10 && (addr % 4) != 0) e = 1;
`endif
        return e;
    endfunction

    // Drive one request and check every cycle until one cycle after its
    // response. With hold=1 req_valid_i stays high afterwards (garbage
    // payload) so the next do_req call forms a back-to-back request.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [10:0] addr, input logic [31:0] wdata, input bit hold);
        bit          err;
        int          n;
        longint      val;
        logic [31:0] exp_rd;
        logic [19:0] item;
        logic [10:0] a;
        int          waited;

        err = model_err(size, addr);
        n   = err ? 0 : (size == 2'b00 ? 1 : (size == 2'b01 ? 2 : 4));
        exp_rd = 32'h0;
        val = 0;
        for (int i = 0; i < n; i++) begin
            a = 11'((addr + i) % 2048);
            if (we) begin
                exp_q.push_back({1'b1, a, 8'((wdata >> (8 * i)) & 32'hFF)});
                ref_mem[a] = 8'((wdata >> (8 * i)) & 32'hFF);
            end else begin
                exp_q.push_back({1'b0, a, 8'h00});
                val = val + longint'(ref_mem[a]) * (longint'(1) << (8 * i));
            end
        end
        if (!err && !we) begin
            if (!uns && n == 1 && val >= 128)   val = val - 256;
            if (!uns && n == 2 && val >= 32768) val = val - 65536;
            exp_rd = 32'(val);
        end

        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        waited = 0;
        while (!req_ready_o && waited < 20) begin
            @(negedge clk_i);
            waited++;
        end
        chk("ready_before_req", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);

        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                req_valid_i    = hold ? 1'b1 : 1'b0;
                req_we_i       = 1'($urandom_range(0, 1));
                req_size_i     = 2'($urandom_range(0, 3));
                req_unsigned_i = 1'($urandom_range(0, 1));
                req_addr_i     = 11'($urandom_range(0, 2047));
                req_wdata_i    = $urandom;
            end
            if (k <= n) begin
                item = exp_q.pop_front();
                chk("acc_mem_addr", 32'(mem_addr_o), 32'(item[18:8]));
                chk("acc_mem_we", 32'(mem_we_o), 32'(item[19]));
                if (item[19])
                    chk("acc_mem_wdata", 32'(mem_wdata_o), 32'(item[7:0]));
                chk("acc_ready_low", 32'(req_ready_o), 32'd0);
                chk("acc_rsp_valid_low", 32'(rsp_valid_o), 32'd0);
            end else if (k == n + 1) begin
                chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
                chk("rsp_err", 32'(rsp_err_o), 32'(err));
                chk("rsp_rdata", rsp_rdata_o, exp_rd);
                chk("rsp_ready_low", 32'(req_ready_o), 32'd0);
                chk("rsp_mem_we", 32'(mem_we_o), 32'd0);
                chk("rsp_mem_addr", 32'(mem_addr_o), 32'd0);
            end else begin
                chk("post_rsp_valid_low", 32'(rsp_valid_o), 32'd0);
                chk("post_ready", 32'(req_ready_o), 32'd1);
                chk("post_rdata_hold", rsp_rdata_o, exp_rd);
                chk("post_err_hold", 32'(rsp_err_o), 32'(err));
                chk("post_mem_wdata", 32'(mem_wdata_o), 32'd0);
            end
        end
    endtask

    task automatic backdoor_write(input logic [10:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        ref_mem[a] = d;
        @(posedge clk_i);
        @(negedge clk_i);
        bd_we = 1'b0;
    endtask

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] wd;
        logic [7:0]  old_b [4];
        int          nbad;
        bit          err_r;
        logic [1:0]  sz;

        vectors     = 0;
        miscompares = 0;
        rst_ni         = 1'b0;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'b00;
        req_unsigned_i = 1'b0;
        req_addr_i     = '0;
        req_wdata_i    = '0;
        bd_we          = 1'b0;
        bd_addr        = '0;
        bd_data        = '0;
        fill_seed      = 8'($urandom);
        fill_en        = 1'b1;
        for (int i = 0; i < 2048; i++)
            ref_mem[i] = 8'(i * 37 + 11) ^ fill_seed;

        // Reset state
        #2;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_err", 32'(rsp_err_o), 32'd0);
        chk("rst_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
        repeat (3) @(negedge clk_i);
        fill_en = 1'b0;
        rst_ni  = 1'b1;
        @(negedge clk_i);

        // Store word, then read parts of it back
        do_req(1'b1, 2'b10, 1'b0, 11'h010, 32'hA1B2C3D4, 1'b0);
        chk("tp_store_rdata_zero", rsp_rdata_o, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 11'h012, 32'h0, 1'b0);
        chk("tp_load_b_signed", rsp_rdata_o, 32'hFFFFFFB2);
        do_req(1'b0, 2'b00, 1'b1, 11'h012, 32'h0, 1'b0);
        chk("tp_load_b_unsigned", rsp_rdata_o, 32'h000000B2);
        do_req(1'b0, 2'b10, 1'b0, 11'h010, 32'h0, 1'b0);
        chk("tp_load_word", rsp_rdata_o, 32'hA1B2C3D4);

        // Half across the top of the address space
        backdoor_write(11'h7FF, 8'h34);
        backdoor_write(11'h000, 8'h92);
        do_req(1'b0, 2'b01, 1'b0, 11'h7FF, 32'h0, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        chk("tp_wrap_half_err", 32'(rsp_err_o), 32'd1);
        chk("tp_wrap_half_rdata", rsp_rdata_o, 32'h0);
`else
        chk("tp_wrap_half_err", 32'(rsp_err_o), 32'd0);
        chk("tp_wrap_half_rdata", rsp_rdata_o, 32'hFFFF9234);
`endif

        // Illegal size, then a normal request clears the error
        do_req(1'b1, 2'b11, 1'b0, 11'h020, 32'h12345678, 1'b0);
        chk("tp_illegal_err", 32'(rsp_err_o), 32'd1);
        do_req(1'b0, 2'b01, 1'b1, 11'h010, 32'h0, 1'b0);
        chk("tp_after_err_clear", 32'(rsp_err_o), 32'd0);
        chk("tp_after_err_rdata", rsp_rdata_o, 32'h0000C3D4);

        // Reset during the second byte of a word store
        wd = $urandom;
        for (int i = 0; i < 4; i++) old_b[i] = ref_mem[11'h100 + 11'(i)];
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_size_i  = 2'b10;
        req_addr_i  = 11'h100;
        req_wdata_i = wd;
        @(posedge clk_i);          // handshake
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("rst_mid_byte0_we", 32'(mem_we_o), 32'd1);
        @(posedge clk_i);          // byte 0 written
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(req_ready_o), 32'd1);
        chk("rst_mid_mem_we", 32'(mem_we_o), 32'd0);
        chk("rst_mid_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("rst_mid_mem_wdata", 32'(mem_wdata_o), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_mid_rdata", rsp_rdata_o, 32'd0);
        chk("rst_mid_err", 32'(rsp_err_o), 32'd0);
        ref_mem[11'h100] = wd[7:0];
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("rst_mid_no_rsp", 32'(rsp_valid_o), 32'd0);
            chk("rst_mid_no_we", 32'(mem_we_o), 32'd0);
        end
        chk("rst_mid_byte0_kept", 32'(mem[11'h100]), 32'(wd[7:0]));
        for (int i = 1; i < 4; i++)
            chk("rst_mid_bytes_unchanged", 32'(mem[11'h100 + 11'(i)]), 32'(old_b[i]));

        // Back-to-back with req_valid_i held high
        do_req(1'b1, 2'b01, 1'b0, 11'h200, 32'h0000BEEF, 1'b1);
        do_req(1'b0, 2'b01, 1'b0, 11'h200, 32'h0, 1'b1);
        do_req(1'b0, 2'b00, 1'b1, 11'h201, 32'h0, 1'b0);
        chk("b2b_last_rdata", rsp_rdata_o, 32'h000000BE);

        // Randomized traffic; weighted toward a small window so loads hit stores
        for (int t = 0; t < 300; t++) begin
            sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            err_r = ($urandom_range(0, 3) == 0);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   err_r ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(11'h7F0, 11'h7FF) + $urandom_range(0, 24)),
                   $urandom, (t != 299) && ($urandom_range(0, 3) == 0));
        end

        // Whole memory image against the reference
        nbad = 0;
        for (int i = 0; i < 2048; i++)
            if (mem[i] !== ref_mem[i]) nbad++;
        chk("mem_image_bad_bytes", 32'(nbad), 32'd0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
